// File: rtl/fib_stream_buf.sv
// ============================================================================
// Module  : fib_stream_buf
// Brief   : Samples a free-running Fibonacci generator, flags modular
//           wrap-around and buffers {wrap, sample} in a FIFO feeding a
//           valid/ready stream. Optional macro FIB_DROP_CNT_EN adds a
//           saturating dropped-sample counter port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_stream_buf #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] fib_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wrap,
    output logic             full,
    output logic             empty,
    output logic             busy
`ifdef FIB_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [c_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0]  count_q;
    logic [WIDTH:0]      mem_q [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_sample;
    logic w_wrap;
    logic w_push;

    always_comb begin
        w_full   = (count_q == c_CNT_W'(DEPTH));
        w_empty  = (count_q == '0);
        w_pop    = !w_empty && out_ready;
        w_sample = (state_q == RUN) && en;
        w_wrap   = prev_valid_q && (fib_in < prev_q);
        // A full FIFO still accepts the sample when the head leaves this edge.
        w_push   = w_sample && (!w_full || w_pop);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (w_wrap) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_sample) begin
            prev_d       = fib_in;
            prev_valid_d = 1'b1;
        end
        if (state_d == IDLE) begin
            prev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= {w_wrap, fib_in};
                wr_ptr_q        <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FIB_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (w_sample && !w_push && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

    assign out_valid = !w_empty;
    assign out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
    assign out_wrap  = mem_q[rd_ptr_q][WIDTH];
    assign full      = w_full;
    assign empty     = w_empty;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fib_stream_buf.sv
// Directed bench for fib_stream_buf (WIDTH=9, DEPTH=4) with a table-driven
// main stream and hand-written multi-cycle corner sequences.
`default_nettype none

module tb_fib_stream_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [8:0] fib_in = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [8:0] out_data;
    logic       out_wrap;
    logic       full;
    logic       empty;
    logic       busy;
`ifdef FIB_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] fibv [40];

    typedef struct {
        logic       en;
        logic [8:0] fib;
        logic       rdy;
        logic       valid;
        logic [8:0] data;
        logic       wrap;
        logic       full;
        logic       empty;
        logic       busy;
    } vec_t;

    vec_t vt [18];

    fib_stream_buf #(.WIDTH(9), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fib_in    (fib_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_wrap  (out_wrap),
        .full      (full),
        .empty     (empty),
        .busy      (busy)
`ifdef FIB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [8:0] f, input logic r);
        en        = e;
        fib_in    = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic fu,
                             input logic em, input logic bu);
        chk({tag, ".valid"}, int'(out_valid), int'(v));
        chk({tag, ".full"},  int'(full),      int'(fu));
        chk({tag, ".empty"}, int'(empty),     int'(em));
        chk({tag, ".busy"},  int'(busy),      int'(bu));
    endtask

    task automatic chk_head(input string tag, input logic [8:0] d, input logic w);
        chk({tag, ".data"}, int'(out_data), int'(d));
        chk({tag, ".wrap"}, int'(out_wrap), int'(w));
    endtask

    task automatic do_reset();
        en = 1'b0; fib_in = '0; out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        fibv[0] = 9'd0;
        fibv[1] = 9'd1;
        for (int k = 2; k < 40; k++) fibv[k] = fibv[k-1] + fibv[k-2];

        // Main stream: first edge only enters RUN, then each sample shows up
        // on the head one edge later; 98 (index 15) is the wrap.
        vt[0] = '{1'b1, fibv[0], 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 1; k <= 15; k++)
            vt[k] = '{1'b1, fibv[k], 1'b1, 1'b1, fibv[k], (k == 15), 1'b0, 1'b0, 1'b1};
        vt[16] = '{1'b1, fibv[16], 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[17] = '{1'b1, fibv[17], 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk_flags("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_head("reset", 9'd0, 1'b0);
`ifdef FIB_DROP_CNT_EN
        chk("reset.drop", int'(drop_cnt), 0);
`endif

        for (int i = 0; i < 18; i++) begin
            string tag;
            tag = $sformatf("stream[%0d]", i);
            step(vt[i].en, vt[i].fib, vt[i].rdy);
            chk_flags(tag, vt[i].valid, vt[i].full, vt[i].empty, vt[i].busy);
            if (vt[i].valid) chk_head(tag, vt[i].data, vt[i].wrap);
        end

        // Backpressure: fill, drop one, then drain in order
        do_reset();
        step(1'b1, 9'd0, 1'b0);
        step(1'b1, 9'd1, 1'b0);
        chk_head("bp.first", 9'd1, 1'b0);
        step(1'b1, 9'd1, 1'b0);
        step(1'b1, 9'd2, 1'b0);
        step(1'b1, 9'd3, 1'b0);
        chk_flags("bp.fill", 1'b1, 1'b1, 1'b0, 1'b1);
        chk_head("bp.fill", 9'd1, 1'b0);
        step(1'b1, 9'd5, 1'b0);
        chk_flags("bp.drop", 1'b1, 1'b1, 1'b0, 1'b1);
        chk_head("bp.drop", 9'd1, 1'b0);
        step(1'b0, 9'd8, 1'b0);
        chk_flags("bp.idle", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 9'd0, 1'b1);
        chk_head("bp.pop1", 9'd1, 1'b0);
        step(1'b0, 9'd0, 1'b1);
        chk_head("bp.pop2", 9'd2, 1'b0);
        step(1'b0, 9'd0, 1'b1);
        chk_head("bp.pop3", 9'd3, 1'b0);
        step(1'b0, 9'd0, 1'b1);
        chk_flags("bp.empty", 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef FIB_DROP_CNT_EN
        chk("bp.drop_cnt", int'(drop_cnt), 1);
`endif

        // Full with simultaneous pop: push accepted, count stays 4
        do_reset();
        step(1'b1, 9'd0, 1'b0);
        step(1'b1, 9'd1, 1'b0);
        step(1'b1, 9'd1, 1'b0);
        step(1'b1, 9'd2, 1'b0);
        step(1'b1, 9'd3, 1'b0);
        step(1'b1, 9'd5, 1'b1);
        chk_flags("fp.pushpop", 1'b1, 1'b1, 1'b0, 1'b1);
        chk_head("fp.pushpop", 9'd1, 1'b0);
        step(1'b0, 9'd0, 1'b1);
        chk_head("fp.d2", 9'd2, 1'b0);
        step(1'b0, 9'd0, 1'b1);
        chk_head("fp.d3", 9'd3, 1'b0);
        step(1'b0, 9'd0, 1'b1);
        chk_head("fp.d5", 9'd5, 1'b0);
        chk_flags("fp.last", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FIB_DROP_CNT_EN
        chk("fp.drop_cnt", int'(drop_cnt), 0);
`endif

        // Enable toggle: no sample on toggle edges, prev_valid cleared
        do_reset();
        step(1'b1, 9'd0, 1'b1);
        step(1'b1, 9'd1, 1'b1);
        step(1'b1, 9'd1, 1'b1);
        step(1'b1, 9'd2, 1'b1);
        chk_head("en.pre", 9'd2, 1'b0);
        step(1'b0, 9'd3, 1'b1);
        chk_flags("en.off", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 9'd5, 1'b1);
        chk_flags("en.reenter", 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 9'd0, 1'b1);
        chk_flags("en.first", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_head("en.first", 9'd0, 1'b0);
        step(1'b1, 9'd1, 1'b1);
        chk_head("en.second", 9'd1, 1'b0);
        chk("en.still_run", int'(busy), 1);

        // Wrap while full: 98 dropped, DRAIN entered, wrap never visible
        do_reset();
        for (int k = 0; k <= 15; k++) step(1'b1, fibv[k], 1'b0);
        chk_flags("wf.full", 1'b1, 1'b1, 1'b0, 1'b1);
        chk_head("wf.full", 9'd1, 1'b0);
        step(1'b1, fibv[16], 1'b1);
        chk_head("wf.d1", 9'd1, 1'b0);
        step(1'b1, fibv[17], 1'b1);
        chk_head("wf.d2", 9'd2, 1'b0);
        step(1'b1, fibv[18], 1'b1);
        chk_head("wf.d3", 9'd3, 1'b0);
        chk_flags("wf.drain", 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, fibv[19], 1'b1);
        chk_flags("wf.empty", 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, fibv[20], 1'b1);
        chk_flags("wf.idle", 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef FIB_DROP_CNT_EN
        chk("wf.drop_cnt", int'(drop_cnt), 11);
`endif

        // Asynchronous reset between edges with 3 entries buffered
        do_reset();
        step(1'b1, 9'd0, 1'b0);
        step(1'b1, 9'd1, 1'b0);
        step(1'b1, 9'd1, 1'b0);
        step(1'b1, 9'd2, 1'b0);
        chk_flags("ar.pre", 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_flags("ar.async", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_head("ar.async", 9'd0, 1'b0);
`ifdef FIB_DROP_CNT_EN
        chk("ar.drop_cnt", int'(drop_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 9'd0, 1'b1);
        chk_flags("ar.post", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fib_stream_buf.md
# fib_stream_buf

Downstream consumer of the free-running Fibonacci generator. It samples the generator's `WIDTH`-bit output every cycle while enabled and detects modular wrap-around (a sample smaller than its predecessor). It buffers samples in a `DEPTH`-entry FIFO and presents them on a valid/ready stream, so that slower logic can consume the sequence without losing ordering.

## Interface
Parameters:
- `WIDTH`, default 9: sample width; must match the generator output width.
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  capture enable.
- `fib_in`  in  `WIDTH`  generator output, sampled each cycle.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_valid`  out  1  head entry present.
- `out_data`  out  `WIDTH`  head sample value.
- `out_wrap`  out  1  head sample is the first sample after a wrap.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `busy`  out  1  state != IDLE.
- `drop_cnt`  out  8  dropped-sample counter; present only with `FIB_DROP_CNT_EN`.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN on an edge with `en`=1. No sample is taken on that edge.
  - RUN, `en`=1: sample `fib_in`. Go to DRAIN if a wrap is detected; otherwise stay in RUN.
  - RUN, `en`=0 → IDLE. No sample is taken.
  - DRAIN: `en` is ignored and no samples are taken. DRAIN → IDLE on an edge where count==0.
- Wrap detection:
  - `prev` register plus `prev_valid` flag.
  - A wrap is `prev_valid && fib_in < prev`.
  - Every sample updates `prev` and sets `prev_valid`.
  - `prev_valid` clears when the block enters IDLE.
- Push: each sample writes entry {wrap, `fib_in`}.
  - The push is accepted if `!full` or a pop occurs on the same edge.
  - Otherwise the sample is dropped. On a dropped wrap sample, the flag is lost but the block still enters DRAIN.
- Pop: `out_valid && out_ready`. Count is unchanged on a simultaneous push and pop.
- `out_valid` = `!empty`. `out_data`/`out_wrap` are combinational reads of the head entry.
- Pointers wrap modulo `DEPTH`. Count has width log2(`DEPTH`)+1.
- `out_valid` never drops without a pop, except on reset. `out_data` is stable while `out_valid && !out_ready`.

## Timing
- Latency: a sample taken at edge N is visible on `out_*` after edge N if the FIFO was empty.
- Throughput: 1 push and 1 pop per cycle.
- Reset values:
  - State IDLE; count 0; pointers 0; `prev_valid` 0; memory cleared to 0.
  - `out_valid` 0, `out_data` 0, `out_wrap` 0, `full` 0, `empty` 1, `busy` 0, `drop_cnt` 0.
- Reset mid-operation: all contents are discarded immediately (asynchronous reset) and the outputs take their reset values.
- The wrap test compares unsigned `WIDTH`-bit values. No arithmetic widening is performed.

## Configuration
- `FIB_DROP_CNT_EN` defined:
  - `drop_cnt` port exists.
  - It increments by 1 on every dropped sample and saturates at 255.
  - It clears only on `rst`.
- `FIB_DROP_CNT_EN` undefined: no port and no counter logic. Drops are silent.

## Test plan
- Basic stream: reset with the generator; `en`=1, `out_ready`=1 → the `out_data` stream is 1,1,2,3,5,8,...,233,377,98 (the first post-reset generator output, 0, coincides with the IDLE → RUN edge). `out_wrap`=1 only on 98, followed by DRAIN → IDLE with `busy`=0.
- Backpressure: `out_ready`=0 with `DEPTH`=4 → `full`=1 after 4 samples and the head is held at its first value. Release `out_ready` → the 4 buffered values come out in order. With the macro, `drop_cnt` equals the number of samples taken while `full` with no pop.
- Full with simultaneous pop: `full`=1, `out_ready`=1, sample taken → push accepted, count stays 4, no drop.
- Enable toggle: `en` deasserted mid-RUN, then reasserted → no sample on the toggle edges. After re-entry, `prev_valid`=0, so the first sample is never flagged as a wrap.
- Wrap while full: `out_ready`=0 through the 377 → 98 transition → the 98 is dropped, the state goes to DRAIN, and `out_wrap` is never seen. After `out_ready`=1 the FIFO drains and the block returns to IDLE.
- Asynchronous reset: assert `rst` mid-stream with 3 entries buffered, between clock edges → `out_valid`=0, `empty`=1 immediately, and state is IDLE.
